// File: rtl/pipeline_pkg.sv
// Shared encodings for the decode stage: opcodes, R-type functs, ALU selects
// and the per-instruction decode record.
package pipeline_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic       uses_rs;
    logic       uses_rt;
    logic       wen;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       imm_zext;
    logic       illegal;
    logic [4:0] dest;
    logic [2:0] alu_op;
  } decode_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// Signal bundle between the decode stage and its neighbours (IF/ID, regfile,
// writeback ports, EX). slave is the stage's own view, master the environment's.
interface id_ex_stage_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  if_valid;
  logic [31:0]           if_instr;
  logic [DATA_WIDTH-1:0] if_pc;
  logic                  flush;

  logic [4:0]            rf_addr_1;
  logic [4:0]            rf_addr_2;
  logic [DATA_WIDTH-1:0] rf_data_1;
  logic [DATA_WIDTH-1:0] rf_data_2;

  logic                  exm_wen;
  logic [4:0]            exm_rd;
  logic [DATA_WIDTH-1:0] exm_result;
  logic                  mwb_wen;
  logic [4:0]            mwb_rd;
  logic [DATA_WIDTH-1:0] mwb_data;

  // Flow control: stall_out high means IF/ID must hold its slot this cycle;
  // ex_valid high means the ID/EX register carries a real instruction, and
  // when low every ex_* control is 0 (a bubble).
  logic                  stall_out;
  logic                  ex_valid;
  logic [DATA_WIDTH-1:0] ex_pc;
  logic [DATA_WIDTH-1:0] ex_op1;
  logic [DATA_WIDTH-1:0] ex_op2;
  logic [DATA_WIDTH-1:0] ex_imm;
  logic [4:0]            ex_rd;
  logic                  ex_wen;
  logic                  ex_memread;
  logic                  ex_memwrite;
  logic                  ex_branch;
  logic [2:0]            ex_alu_op;
  logic                  ex_illegal;

  modport slave (
    input  if_valid, if_instr, if_pc, flush,
    input  rf_data_1, rf_data_2,
    input  exm_wen, exm_rd, exm_result, mwb_wen, mwb_rd, mwb_data,
    output rf_addr_1, rf_addr_2, stall_out,
    output ex_valid, ex_pc, ex_op1, ex_op2, ex_imm, ex_rd,
    output ex_wen, ex_memread, ex_memwrite, ex_branch, ex_alu_op, ex_illegal
  );

  modport master (
    output if_valid, if_instr, if_pc, flush,
    output rf_data_1, rf_data_2,
    output exm_wen, exm_rd, exm_result, mwb_wen, mwb_rd, mwb_data,
    input  rf_addr_1, rf_addr_2, stall_out,
    input  ex_valid, ex_pc, ex_op1, ex_op2, ex_imm, ex_rd,
    input  ex_wen, ex_memread, ex_memwrite, ex_branch, ex_alu_op, ex_illegal
  );

endinterface

// File: rtl/forward_mux.sv
// Operand bypass: picks the youngest in-flight write to the source register,
// falling back to the register-file read value.
module forward_mux
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FWD_EN     = 1
) (
  input  logic [4:0]            src_addr,
  input  logic [DATA_WIDTH-1:0] rf_data,
  input  logic                  exm_wen,
  input  logic [4:0]            exm_rd,
  input  logic [DATA_WIDTH-1:0] exm_result,
  input  logic                  mwb_wen,
  input  logic [4:0]            mwb_rd,
  input  logic [DATA_WIDTH-1:0] mwb_data,
  output logic [DATA_WIDTH-1:0] value
);

  logic exm_hit;
  logic mwb_hit;

  assign exm_hit = exm_wen && (exm_rd == src_addr) && (src_addr != REG_ZERO);
  // The regfile commits on the edge that ends this cycle, so its read data is
  // still stale when MEM/WB targets the same register.
  assign mwb_hit = mwb_wen && (mwb_rd == src_addr) && (src_addr != REG_ZERO);

  always_comb begin
    value = rf_data;
    if (FWD_EN != 0) begin
      if (exm_hit) begin
        value = exm_result;
      end else if (mwb_hit) begin
        value = mwb_data;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// Instruction decode and ID/EX pipeline register: field split, control decode,
// operand forwarding and load-use stall generation.
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FWD_EN     = 1
) (
  input  logic          clock,
  input  logic          reset,
  id_ex_stage_if.slave  bus
);

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;
  logic [5:0]  funct;

  assign op    = bus.if_instr[31:26];
  assign rs    = bus.if_instr[25:21];
  assign rt    = bus.if_instr[20:16];
  assign rd    = bus.if_instr[15:11];
  assign imm   = bus.if_instr[15:0];
  assign funct = bus.if_instr[5:0];

  assign bus.rf_addr_1 = rs;
  assign bus.rf_addr_2 = rt;

  decode_t dec;

  always_comb begin
    dec        = '0;
    dec.alu_op = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        dec.uses_rs = 1'b1;
        dec.uses_rt = 1'b1;
        dec.dest    = rd;
        dec.wen     = 1'b1;
        case (funct)
          FN_ADD:  dec.alu_op = ALU_ADD;
          FN_SUB:  dec.alu_op = ALU_SUB;
          FN_AND:  dec.alu_op = ALU_AND;
          FN_OR:   dec.alu_op = ALU_OR;
          FN_SLT:  dec.alu_op = ALU_SLT;
          default: begin
            dec.wen     = 1'b0;
            dec.illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI, OP_SLTI: begin
        dec.uses_rs = 1'b1;
        dec.dest    = rt;
        dec.wen     = 1'b1;
        dec.alu_op  = (op == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      OP_ANDI, OP_ORI: begin
        dec.uses_rs  = 1'b1;
        dec.dest     = rt;
        dec.wen      = 1'b1;
        dec.imm_zext = 1'b1;
        dec.alu_op   = (op == OP_ORI) ? ALU_OR : ALU_AND;
      end
      OP_LW: begin
        dec.uses_rs = 1'b1;
        dec.dest    = rt;
        dec.wen     = 1'b1;
        dec.memread = 1'b1;
      end
      OP_SW: begin
        dec.uses_rs  = 1'b1;
        dec.uses_rt  = 1'b1;
        dec.memwrite = 1'b1;
      end
      OP_BEQ: begin
        dec.uses_rs = 1'b1;
        dec.uses_rt = 1'b1;
        dec.branch  = 1'b1;
        dec.alu_op  = ALU_SUB;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  // Writes to r0 are architecturally dropped, so they never name a destination.
  logic       dec_wen;
  logic [4:0] dec_rd;

  assign dec_wen = dec.wen && (dec.dest != REG_ZERO);
  assign dec_rd  = dec_wen ? dec.dest : REG_ZERO;

  logic [DATA_WIDTH-1:0] imm_ext;

  assign imm_ext = dec.imm_zext ? {{(DATA_WIDTH-16){1'b0}}, imm}
                                : {{(DATA_WIDTH-16){imm[15]}}, imm};

  logic [DATA_WIDTH-1:0] op1_fwd;
  logic [DATA_WIDTH-1:0] op2_fwd;

  forward_mux #(.DATA_WIDTH(DATA_WIDTH), .FWD_EN(FWD_EN)) u_fwd_rs (
    .src_addr   (rs),
    .rf_data    (bus.rf_data_1),
    .exm_wen    (bus.exm_wen),
    .exm_rd     (bus.exm_rd),
    .exm_result (bus.exm_result),
    .mwb_wen    (bus.mwb_wen),
    .mwb_rd     (bus.mwb_rd),
    .mwb_data   (bus.mwb_data),
    .value      (op1_fwd)
  );

  forward_mux #(.DATA_WIDTH(DATA_WIDTH), .FWD_EN(FWD_EN)) u_fwd_rt (
    .src_addr   (rt),
    .rf_data    (bus.rf_data_2),
    .exm_wen    (bus.exm_wen),
    .exm_rd     (bus.exm_rd),
    .exm_result (bus.exm_result),
    .mwb_wen    (bus.mwb_wen),
    .mwb_rd     (bus.mwb_rd),
    .mwb_data   (bus.mwb_data),
    .value      (op2_fwd)
  );

  logic                  ex_valid_q;
  logic [DATA_WIDTH-1:0] ex_pc_q;
  logic [DATA_WIDTH-1:0] ex_op1_q;
  logic [DATA_WIDTH-1:0] ex_op2_q;
  logic [DATA_WIDTH-1:0] ex_imm_q;
  logic [4:0]            ex_rd_q;
  logic                  ex_wen_q;
  logic                  ex_memread_q;
  logic                  ex_memwrite_q;
  logic                  ex_branch_q;
  logic [2:0]            ex_alu_op_q;
  logic                  ex_illegal_q;

  // A load in EX has no data until MEM, so a consumer in ID must wait a cycle.
  logic hazard;

  assign hazard = bus.if_valid && ex_valid_q && ex_memread_q &&
                  (ex_rd_q != REG_ZERO) &&
                  ((dec.uses_rs && (ex_rd_q == rs)) ||
                   (dec.uses_rt && (ex_rd_q == rt)));

  assign bus.stall_out = hazard && !bus.flush;

  always_ff @(posedge clock) begin
    if (reset || bus.flush || hazard || !bus.if_valid) begin
      ex_valid_q    <= 1'b0;
      ex_pc_q       <= '0;
      ex_op1_q      <= '0;
      ex_op2_q      <= '0;
      ex_imm_q      <= '0;
      ex_rd_q       <= REG_ZERO;
      ex_wen_q      <= 1'b0;
      ex_memread_q  <= 1'b0;
      ex_memwrite_q <= 1'b0;
      ex_branch_q   <= 1'b0;
      ex_alu_op_q   <= ALU_ADD;
      ex_illegal_q  <= 1'b0;
    end else begin
      ex_valid_q    <= 1'b1;
      ex_pc_q       <= bus.if_pc;
      ex_op1_q      <= op1_fwd;
      ex_op2_q      <= op2_fwd;
      ex_imm_q      <= imm_ext;
      ex_rd_q       <= dec_rd;
      ex_wen_q      <= dec_wen;
      ex_memread_q  <= dec.memread;
      ex_memwrite_q <= dec.memwrite;
      ex_branch_q   <= dec.branch;
      ex_alu_op_q   <= dec.alu_op;
      ex_illegal_q  <= dec.illegal;
    end
  end

  assign bus.ex_valid    = ex_valid_q;
  assign bus.ex_pc       = ex_pc_q;
  assign bus.ex_op1      = ex_op1_q;
  assign bus.ex_op2      = ex_op2_q;
  assign bus.ex_imm      = ex_imm_q;
  assign bus.ex_rd       = ex_rd_q;
  assign bus.ex_wen      = ex_wen_q;
  assign bus.ex_memread  = ex_memread_q;
  assign bus.ex_memwrite = ex_memwrite_q;
  assign bus.ex_branch   = ex_branch_q;
  assign bus.ex_alu_op   = ex_alu_op_q;
  assign bus.ex_illegal  = ex_illegal_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vectors push expected ID/EX contents and
// stall values; independent monitors pop and compare.
module tb_id_ex_stage;
  import pipeline_pkg::*;

  localparam int W = 152;

  logic clock;
  logic reset;

  id_ex_stage_if #(.DATA_WIDTH(32)) bus ();

  id_ex_stage #(.DATA_WIDTH(32), .FWD_EN(1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // scoreboard state
  logic [W-1:0] exp_q[$];
  logic [8:0]   stall_exp_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           vec_id = 0;

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  // driver tasks
  task automatic begin_vec(input logic [31:0] pc);
    @(negedge clock);
    #1;
    vec_id         = vec_id + 1;
    reset          = 1'b0;
    bus.if_valid   = 1'b1;
    bus.if_instr   = 32'h0;
    bus.if_pc      = pc;
    bus.flush      = 1'b0;
    bus.rf_data_1  = 32'h0;
    bus.rf_data_2  = 32'h0;
    bus.exm_wen    = 1'b0;
    bus.exm_rd     = 5'd0;
    bus.exm_result = 32'h0;
    bus.mwb_wen    = 1'b0;
    bus.mwb_rd     = 5'd0;
    bus.mwb_data   = 32'h0;
  endtask

  task automatic push_exp(input logic chk_stall, input logic stall, input logic valid,
                          input logic [31:0] pc, input logic [31:0] op1,
                          input logic [31:0] op2, input logic [31:0] imm,
                          input logic [4:0] rd, input logic wen, input logic mr,
                          input logic mw, input logic br, input logic [2:0] alu,
                          input logic ill);
    logic [7:0] tag;
    tag = vec_id[7:0];
    exp_q.push_back({tag, chk_stall, stall, valid, pc, op1, op2, imm, rd,
                     wen, mr, mw, br, alu, ill});
    if (chk_stall) stall_exp_q.push_back({tag, stall});
  endtask

  task automatic push_bubble(input logic chk_stall, input logic stall);
    push_exp(chk_stall, stall, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0,
             1'b0, 1'b0, 1'b0, 1'b0, ALU_ADD, 1'b0);
  endtask

  task automatic vec_lw_r5(input logic [31:0] pc);
    begin_vec(pc);
    bus.if_instr  = i_type(6'h23, 5'd0, 5'd5, 16'd4);
    bus.rf_data_2 = 32'h55;
    push_exp(1'b1, 1'b0, 1'b1, pc, 32'h0, 32'h55, 32'h4, 5'd5,
             1'b1, 1'b1, 1'b0, 1'b0, ALU_ADD, 1'b0);
  endtask

  // monitor: ID/EX contents, sampled on the falling edge after each update
  logic [W-1:0] mon_e;
  logic [141:0] mon_act;
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      mon_e   = exp_q.pop_front();
      mon_act = {bus.ex_valid, bus.ex_pc, bus.ex_op1, bus.ex_op2, bus.ex_imm, bus.ex_rd,
                 bus.ex_wen, bus.ex_memread, bus.ex_memwrite, bus.ex_branch,
                 bus.ex_alu_op, bus.ex_illegal};
      n_cmp = n_cmp + 1;
      if (mon_act !== mon_e[141:0]) begin
        n_bad = n_bad + 1;
        $display("FAIL vec%0d ex_outputs got %h exp %h", mon_e[151:144], mon_act, mon_e[141:0]);
      end
    end
  end

  // monitor: stall_out, sampled mid-cycle while the vector's inputs are held
  logic [8:0] mon_s;
  always @(negedge clock) begin
    #3;
    if (stall_exp_q.size() > 0) begin
      mon_s = stall_exp_q.pop_front();
      n_cmp = n_cmp + 1;
      if (bus.stall_out !== mon_s[0]) begin
        n_bad = n_bad + 1;
        $display("FAIL vec%0d stall_out got %b exp %b", mon_s[8:1], bus.stall_out, mon_s[0]);
      end
    end
  end

  initial begin
    reset          = 1'b1;
    bus.if_valid   = 1'b0;
    bus.if_instr   = 32'h0;
    bus.if_pc      = 32'h0;
    bus.flush      = 1'b0;
    bus.rf_data_1  = 32'h0;
    bus.rf_data_2  = 32'h0;
    bus.exm_wen    = 1'b0;
    bus.exm_rd     = 5'd0;
    bus.exm_result = 32'h0;
    bus.mwb_wen    = 1'b0;
    bus.mwb_rd     = 5'd0;
    bus.mwb_data   = 32'h0;

    // reset: everything clears, stall reads 0 once the register is known
    begin_vec(32'h0); reset = 1'b1; bus.if_valid = 1'b0;
    push_bubble(1'b0, 1'b0);
    begin_vec(32'h0); reset = 1'b1; bus.if_instr = r_type(5'd1, 5'd2, 5'd3, 6'h20);
    push_bubble(1'b1, 1'b0);

    // add r3,r1,r2 plain
    begin_vec(32'h100); bus.if_instr = 32'h00221820;
    bus.rf_data_1 = 32'h1; bus.rf_data_2 = 32'h2;
    push_exp(1'b1, 1'b0, 1'b1, 32'h100, 32'h1, 32'h2, 32'h1820, 5'd3,
             1'b1, 1'b0, 1'b0, 1'b0, ALU_ADD, 1'b0);

    // forwarding priority: EX/MEM over MEM/WB
    begin_vec(32'h104); bus.if_instr = 32'h00221820;
    bus.rf_data_1 = 32'h1; bus.rf_data_2 = 32'h2;
    bus.exm_wen = 1'b1; bus.exm_rd = 5'd1; bus.exm_result = 32'hAA;
    bus.mwb_wen = 1'b1; bus.mwb_rd = 5'd1; bus.mwb_data = 32'hBB;
    push_exp(1'b1, 1'b0, 1'b1, 32'h104, 32'hAA, 32'h2, 32'h1820, 5'd3,
             1'b1, 1'b0, 1'b0, 1'b0, ALU_ADD, 1'b0);

    begin_vec(32'h108); bus.if_instr = 32'h00221820;
    bus.rf_data_1 = 32'h1; bus.rf_data_2 = 32'h2;
    bus.exm_rd = 5'd1; bus.exm_result = 32'hAA;
    bus.mwb_wen = 1'b1; bus.mwb_rd = 5'd1; bus.mwb_data = 32'hBB;
    push_exp(1'b1, 1'b0, 1'b1, 32'h108, 32'hBB, 32'h2, 32'h1820, 5'd3,
             1'b1, 1'b0, 1'b0, 1'b0, ALU_ADD, 1'b0);

    begin_vec(32'h10C); bus.if_instr = 32'h00221820;
    bus.rf_data_1 = 32'h11; bus.rf_data_2 = 32'h2;
    bus.exm_wen = 1'b1; bus.exm_rd = 5'd0; bus.exm_result = 32'hAA;
    bus.mwb_wen = 1'b1; bus.mwb_rd = 5'd0; bus.mwb_data = 32'hBB;
    push_exp(1'b1, 1'b0, 1'b1, 32'h10C, 32'h11, 32'h2, 32'h1820, 5'd3,
             1'b1, 1'b0, 1'b0, 1'b0, ALU_ADD, 1'b0);

    // load-use: one bubble, then the add issues with MEM/WB data
    vec_lw_r5(32'h110);
    begin_vec(32'h114); bus.if_instr = r_type(5'd5, 5'd1, 5'd6, 6'h20);
    bus.rf_data_1 = 32'h999; bus.rf_data_2 = 32'h7;
    push_bubble(1'b1, 1'b1);
    begin_vec(32'h114); bus.if_instr = r_type(5'd5, 5'd1, 5'd6, 6'h20);
    bus.rf_data_1 = 32'h999; bus.rf_data_2 = 32'h7;
    bus.mwb_wen = 1'b1; bus.mwb_rd = 5'd5; bus.mwb_data = 32'h1234;
    push_exp(1'b1, 1'b0, 1'b1, 32'h114, 32'h1234, 32'h7, 32'h3020, 5'd6,
             1'b1, 1'b0, 1'b0, 1'b0, ALU_ADD, 1'b0);

    // sw r5 after lw r5 stalls on rt
    vec_lw_r5(32'h118);
    begin_vec(32'h11C); bus.if_instr = i_type(6'h2B, 5'd1, 5'd5, 16'd8);
    bus.rf_data_1 = 32'h10; bus.rf_data_2 = 32'h20;
    push_bubble(1'b1, 1'b1);
    begin_vec(32'h11C); bus.if_instr = i_type(6'h2B, 5'd1, 5'd5, 16'd8);
    bus.rf_data_1 = 32'h10; bus.rf_data_2 = 32'h20;
    push_exp(1'b1, 1'b0, 1'b1, 32'h11C, 32'h10, 32'h20, 32'h8, 5'd0,
             1'b0, 1'b0, 1'b1, 1'b0, ALU_ADD, 1'b0);

    // addi r7,r0,5 after lw r5 does not stall
    vec_lw_r5(32'h120);
    begin_vec(32'h124); bus.if_instr = i_type(6'h08, 5'd0, 5'd7, 16'd5);
    bus.rf_data_2 = 32'h33;
    push_exp(1'b1, 1'b0, 1'b1, 32'h124, 32'h0, 32'h33, 32'h5, 5'd7,
             1'b1, 1'b0, 1'b0, 1'b0, ALU_ADD, 1'b0);

    // immediate extension and r0 destination
    begin_vec(32'h128); bus.if_instr = i_type(6'h08, 5'd0, 5'd2, 16'hFFFF);
    push_exp(1'b1, 1'b0, 1'b1, 32'h128, 32'h0, 32'h0, 32'hFFFFFFFF, 5'd2,
             1'b1, 1'b0, 1'b0, 1'b0, ALU_ADD, 1'b0);
    begin_vec(32'h12C); bus.if_instr = i_type(6'h0D, 5'd0, 5'd2, 16'hFFFF);
    push_exp(1'b1, 1'b0, 1'b1, 32'h12C, 32'h0, 32'h0, 32'h0000FFFF, 5'd2,
             1'b1, 1'b0, 1'b0, 1'b0, ALU_OR, 1'b0);
    begin_vec(32'h130); bus.if_instr = r_type(5'd1, 5'd2, 5'd0, 6'h20);
    bus.rf_data_1 = 32'h1; bus.rf_data_2 = 32'h2;
    push_exp(1'b1, 1'b0, 1'b1, 32'h130, 32'h1, 32'h2, 32'h20, 5'd0,
             1'b0, 1'b0, 1'b0, 1'b0, ALU_ADD, 1'b0);

    // flush beats a pending hazard
    vec_lw_r5(32'h134);
    begin_vec(32'h138); bus.if_instr = r_type(5'd5, 5'd1, 5'd6, 6'h20);
    bus.flush = 1'b1;
    push_bubble(1'b1, 1'b0);

    // unknown opcode
    begin_vec(32'h13C); bus.if_instr = {6'h3F, 26'h0};
    push_exp(1'b1, 1'b0, 1'b1, 32'h13C, 32'h0, 32'h0, 32'h0, 5'd0,
             1'b0, 1'b0, 1'b0, 1'b0, ALU_ADD, 1'b1);

    // reset while a load-use hazard is pending
    vec_lw_r5(32'h140);
    begin_vec(32'h144); reset = 1'b1; bus.if_instr = r_type(5'd5, 5'd1, 5'd6, 6'h20);
    push_bubble(1'b1, 1'b1);
    begin_vec(32'h144); bus.if_instr = r_type(5'd5, 5'd1, 5'd6, 6'h20);
    bus.rf_data_1 = 32'h77; bus.rf_data_2 = 32'h8;
    push_exp(1'b1, 1'b0, 1'b1, 32'h144, 32'h77, 32'h8, 32'h3020, 5'd6,
             1'b1, 1'b0, 1'b0, 1'b0, ALU_ADD, 1'b0);

    // remaining opcodes
    begin_vec(32'h148); bus.if_instr = i_type(6'h04, 5'd1, 5'd2, 16'hFFFC);
    bus.rf_data_1 = 32'h3; bus.rf_data_2 = 32'h3;
    push_exp(1'b1, 1'b0, 1'b1, 32'h148, 32'h3, 32'h3, 32'hFFFFFFFC, 5'd0,
             1'b0, 1'b0, 1'b0, 1'b1, ALU_SUB, 1'b0);
    begin_vec(32'h14C); bus.if_instr = i_type(6'h0A, 5'd1, 5'd4, 16'h8000);
    bus.rf_data_1 = 32'h5;
    push_exp(1'b1, 1'b0, 1'b1, 32'h14C, 32'h5, 32'h0, 32'hFFFF8000, 5'd4,
             1'b1, 1'b0, 1'b0, 1'b0, ALU_SLT, 1'b0);
    begin_vec(32'h150); bus.if_instr = i_type(6'h0C, 5'd1, 5'd4, 16'h8000);
    bus.rf_data_1 = 32'h5;
    push_exp(1'b1, 1'b0, 1'b1, 32'h150, 32'h5, 32'h0, 32'h00008000, 5'd4,
             1'b1, 1'b0, 1'b0, 1'b0, ALU_AND, 1'b0);

    // empty IF/ID slot
    begin_vec(32'h154); bus.if_valid = 1'b0; bus.if_instr = 32'h00221820;
    bus.rf_data_1 = 32'h1; bus.rf_data_2 = 32'h2;
    push_bubble(1'b1, 1'b0);

    // drain, then make sure every expectation was consumed
    repeat (3) @(negedge clock);
    #4;
    n_cmp = n_cmp + 1;
    if (exp_q.size() != 0 || stall_exp_q.size() != 0) begin
      n_bad = n_bad + 1;
      $display("FAIL drain leftover got %0d exp 0", exp_q.size() + stall_exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Instruction-decode stage and ID/EX pipeline register. Sits directly upstream of the register file's consumers.
- Splits the IF/ID instruction and drives the two register-file read addresses combinationally.
- Takes the register-file read data, which is sampled on the clock's falling edge and so is valid before the next rising edge. Applies EX/MEM and MEM/WB forwarding to it.
- Detects load-use hazards and registers the decoded operands and controls for the EX stage.

Parameters:
- DATA_WIDTH, 32, width of operands, PC and immediates.
- FWD_EN, 1, 1 enables forwarding muxes; 0 always passes register-file data through.

Ports:
- clock  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset, sampled on the rising edge of clock.
- if_valid  in  1  IF/ID slot holds a real instruction.
- if_instr  in  32  IF/ID instruction word.
- if_pc  in  DATA_WIDTH  IF/ID PC.
- flush  in  1  branch taken / redirect; kill the instruction being decoded.
- rf_addr_1  out  5  register-file read address 1 (rs).
- rf_addr_2  out  5  register-file read address 2 (rt).
- rf_data_1  in  DATA_WIDTH  register-file read data 1.
- rf_data_2  in  DATA_WIDTH  register-file read data 2.
- exm_wen, exm_rd, exm_result  in  1/5/DATA_WIDTH  EX/MEM writeback intent and ALU result.
- mwb_wen, mwb_rd, mwb_data  in  1/5/DATA_WIDTH  MEM/WB writeback intent and data; the same values feed the register file's write port.
- stall_out  out  1  hold PC and IF/ID this cycle.
- ex_valid  out  1  ID/EX slot valid.
- ex_pc  out  DATA_WIDTH  registered PC.
- ex_op1, ex_op2  out  DATA_WIDTH  forwarded rs and rt values.
- ex_imm  out  DATA_WIDTH  extended immediate.
- ex_rd  out  5  destination register.
- ex_wen, ex_memread, ex_memwrite, ex_branch  out  1 each  control bits.
- ex_alu_op  out  3  ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT.
- ex_illegal  out  1  unknown opcode decoded.

Behaviour:
- Field extraction from if_instr:
  - op = [31:26], rs = [25:21], rt = [20:16], rd = [15:11], imm = [15:0], funct = [5:0].
  - rf_addr_1 = rs and rf_addr_2 = rt, purely combinational, including during a stall.
- Decode table:
  - R-type (op 0x00): dest rd; uses rs and rt; funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt; any other funct sets ex_illegal.
  - addi 0x08 and slti 0x0A: sign-extended immediate; dest rt; uses rs.
  - andi 0x0C and ori 0x0D: zero-extended immediate; dest rt; uses rs.
  - lw 0x23: dest rt; memread; ALU_ADD; sign-extended immediate.
  - sw 0x2B: uses rs and rt; memwrite; ALU_ADD; ex_wen = 0.
  - beq 0x04: uses rs and rt; branch; ALU_SUB; ex_wen = 0.
  - Any other op: NOP controls (all control bits 0) and ex_illegal = 1.
- ex_wen is forced to 0 when the destination is r0. ex_rd is 0 whenever ex_wen = 0.
- Forwarding (comb, FWD_EN = 1), per source s:
  - First priority: exm_wen && exm_rd == s && s != 0 -> exm_result.
  - Second priority: mwb_wen && mwb_rd == s && s != 0 -> mwb_data.
  - Otherwise: rf_data.
  - The MEM/WB path is required because the register file writes on the rising edge that ends the cycle, so a same-cycle read returns the old value.
- Load-use hazard:
  - hazard = if_valid && ex_valid && ex_memread && ex_rd != 0 && ((uses_rs && ex_rd == rs) || (uses_rt && ex_rd == rt)).
  - stall_out = hazard && !flush.
- Rising-edge update, in priority order:
  - reset: all ex_* outputs go to 0, including ex_valid = 0; stall_out therefore reads 0.
  - flush: bubble (ex_valid = 0, all controls 0).
  - hazard: bubble; the IF/ID values are held upstream and re-decoded next cycle.
  - otherwise: load the decoded fields; ex_valid = if_valid. An invalid slot carries all controls 0.
- Latency: one cycle from IF/ID to ID/EX. A load-use hazard costs exactly one bubble.
- Reset asserted mid-stall: the next cycle has ex_valid = 0 and stall_out = 0.
- Flush together with hazard: flush wins; no stall.

Decomposition:
- pipeline_pkg holds:
  - opcode and funct localparams;
  - ALU_* 3-bit encodings;
  - REG_ZERO = 5'd0.
- One natural sub-module: forward_mux, instantiated twice (operand, addr, two writeback ports -> value).
- Decode table and hazard logic stay in id_ex_stage.

Test Plan:
- Reset, then add r3,r1,r2 (0x00221820) with regfile r1=1, r2=2 and no writebacks -> next edge ex_valid=1, ex_op1=1, ex_op2=2, ex_rd=3, ex_wen=1, ex_alu_op=ALU_ADD.
- Forwarding priority: same add with exm_wen=1, exm_rd=1, exm_result=0xAA and mwb_wen=1, mwb_rd=1, mwb_data=0xBB -> ex_op1=0xAA. Drop exm_wen -> ex_op1=0xBB. Set both rd=0 -> ex_op1 = rf_data_1.
- Load-use: lw r5,4(r0) then add r6,r5,r1 -> stall_out=1 for exactly one cycle with ex_valid=0 (bubble), then the add issues with ex_op1 taken from the MEM/WB path. sw r5 after lw r5 also stalls; addi r7,r0,5 after lw r5 does not.
- Immediates: addi r2,r0,0xFFFF -> ex_imm=0xFFFFFFFF; ori r2,r0,0xFFFF -> ex_imm=0x0000FFFF. add r0,r1,r2 -> ex_wen=0, ex_rd=0.
- Flush during a stall condition -> stall_out=0 and ex_valid=0 next edge. Opcode 0x3F -> ex_illegal=1 and all controls 0.
- Reset asserted while ex_memread=1 and a hazard is pending -> next edge all ex_* outputs 0 and stall_out=0.
